// File: rtl/shreg_rr_scheduler.sv
// Round-robin front end for a shared multi-bit shift register delay line.
// Grants at most one client per cycle into sr_si and tracks the owner of every
// word in a tag pipeline that advances in lockstep with the external shift register.
module shreg_rr_scheduler #(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned POSITIONS  = 8,
    localparam int unsigned PTR_W     = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [REQUESTERS-1:0]         req_valid,
    input  logic [REQUESTERS*WIDTH-1:0]   req_data,
    output logic [REQUESTERS-1:0]         req_ready,
    output logic [WIDTH-1:0]              sr_si,
    input  logic [WIDTH-1:0]              sr_so,
    output logic [REQUESTERS-1:0]         rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic                          busy,
    output logic [PTR_W-1:0]              grant_ptr
);

    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     gnt_id;
    logic                 gnt_any;
    logic [POSITIONS-1:0] tag_vld_q;
    logic [PTR_W-1:0]     tag_id_q [POSITIONS];

    // Wrapping search from the pointer; reset and flush suppress any grant.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = PTR_W'(idx);
            end
        end
        if (flush || rst) begin
            gnt_any = 1'b0;
            gnt_id  = '0;
        end
    end

    // Grant, data drive and next pointer; no grant inserts a zero bubble.
    always_comb begin
        req_ready = '0;
        sr_si     = '0;
        ptr_d     = ptr_q;
        if (gnt_any) begin
            req_ready         = '0;
            req_ready[gnt_id] = 1'b1;
            sr_si             = req_data[gnt_id*WIDTH +: WIDTH];
            ptr_d             = (gnt_id == PTR_W'(REQUESTERS - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Pointer and tag pipeline; the shift register itself has no reset, so only
    // the valid bits decide whether an emerging word is real.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int unsigned k = 0; k < POSITIONS; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (flush) begin
                tag_vld_q <= '0;
            end else begin
                tag_vld_q <= {tag_vld_q[POSITIONS-2:0], gnt_any};
            end
            tag_id_q[0] <= gnt_id;
            for (int unsigned k = 1; k < POSITIONS; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // Responses decode straight from the last stage so a due word still shows
    // during a flush cycle.
    always_comb begin
        rsp_valid = '0;
        if (tag_vld_q[POSITIONS-1]) begin
            rsp_valid[tag_id_q[POSITIONS-1]] = 1'b1;
        end
    end

    assign rsp_data  = sr_so;
    assign busy      = |tag_vld_q;
    assign grant_ptr = ptr_q;

endmodule
